// File: rtl/riscv_pkg.sv
// Shared decode definitions for the issue block.
// Provides the RV32 opcode constants, the instruction-format enum used by the
// immediate generator and the hazard logic, the issue FSM state enum, and a
// helper that tells whether an instruction reads a given register.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // FMT_NONE marks an unsupported opcode.
  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
  } inst_fmt_e;

  typedef enum logic {
    ST_ISSUE,
    ST_BUBBLE
  } issue_state_e;

  // True when an instruction of format fmt sources register r.
  // SYSTEM is classified as R, so it is treated conservatively as reading rs1/rs2.
  function automatic logic reads_reg(input inst_fmt_e fmt, input logic [31:0] inst,
                                     input logic [4:0] r);
    logic rs1_used;
    logic rs2_used;
    rs1_used = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    rs2_used = fmt inside {FMT_R, FMT_S, FMT_B};
    return (rs1_used && (inst[19:15] == r)) || (rs2_used && (inst[24:20] == r));
  endfunction

endpackage

// File: rtl/decode_issue_ctrl_imm_gen.sv
// imm_gen: purely combinational format classification and immediate extraction.
//   inst : 32-bit instruction word
//   fmt  : instruction format (FMT_NONE for unsupported opcodes)
//   imm  : sign-extended immediate; 0 for R/SYSTEM and unsupported opcodes
// Build option: RV_FP_EN makes FLW (I-format) and FSW (S-format) legal.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] inst,
  output inst_fmt_e   fmt,
  output logic [31:0] imm
);

  // NOTE: every output gets a default before the case statements so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    fmt = FMT_NONE;
    imm = '0;

    case (inst[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt = FMT_I;
      OPC_STORE:                      fmt = FMT_S;
      OPC_BRANCH:                     fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
      OPC_JAL:                        fmt = FMT_J;
      OPC_OP, OPC_SYSTEM:             fmt = FMT_R;
`ifdef RV_FP_EN
      OPC_LOAD_FP:                    fmt = FMT_I;
      OPC_STORE_FP:                   fmt = FMT_S;
`else
      OPC_LOAD_FP, OPC_STORE_FP:      fmt = FMT_NONE;
`endif
      default:                        fmt = FMT_NONE;
    endcase

    case (fmt)
      FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm = {inst[31:12], 12'b0};
      FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: 2-entry fetch buffer, decode and issue register with a
// one-cycle load-use bubble.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_valid/if_ready/if_inst/if_pc fetch handshake and payload
//   flush                           discards everything held, highest priority
//   ex_ready                        execute accepts the issued instruction
//   id_valid, id_inst, id_pc, id_imm, id_rd, id_is_load, id_illegal
//                                   registered issue outputs
// Build option: RV_FP_EN enables FLW/FSW decode (FLW also counts as a load).
module decode_issue_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_inst,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_imm,
  output logic [4:0]      id_rd,
  output logic            id_is_load,
  output logic            id_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_t;

  fetch_t          fifo_q [2];
  fetch_t          fifo_d [2];
  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  issue_state_e    state_q, state_d;
  logic            ld_pending_q, ld_pending_d;
  logic [4:0]      ld_rd_q, ld_rd_d;

  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_inst_q, id_inst_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_imm_q, id_imm_d;
  logic [4:0]      id_rd_q, id_rd_d;
  logic            id_is_load_q, id_is_load_d;
  logic            id_illegal_q, id_illegal_d;

  fetch_t          head;
  inst_fmt_e       head_fmt;
  logic [31:0]     head_imm;
  logic            head_is_load;
  logic            push, pop, id_xfer, ld_record, hazard;

  assign head = fifo_q[rd_ptr_q];

  imm_gen u_imm_gen (
    .inst (head.inst),
    .fmt  (head_fmt),
    .imm  (head_imm)
  );

`ifdef RV_FP_EN
  assign head_is_load = (head.inst[6:0] == OPC_LOAD) || (head.inst[6:0] == OPC_LOAD_FP);
`else
  assign head_is_load = (head.inst[6:0] == OPC_LOAD);
`endif

  // In BUBBLE the register may already hold the dependent instruction; it is
  // hidden from execute until the load result can be forwarded.
  assign id_valid = id_valid_q && (state_q == ST_ISSUE);
  // rst_n gates if_ready so fetch sees no handshake while reset is asserted.
  assign if_ready = rst_n && (count_q < 2'd2) && !flush;
  assign push     = if_valid && if_ready;
  assign id_xfer  = id_valid && ex_ready;
  assign pop      = (count_q != 2'd0) && (state_q == ST_ISSUE) &&
                    (!id_valid_q || ex_ready) && !flush;

  // A load leaving this cycle and the load that left last cycle are both
  // checked against the head being popped now.
  assign ld_record = id_xfer && id_is_load_q && (id_rd_q != 5'd0);
  assign hazard    = (ld_record    && reads_reg(head_fmt, head.inst, id_rd_q)) ||
                     (ld_pending_q && reads_reg(head_fmt, head.inst, ld_rd_q));

  always_comb begin
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    state_d      = state_q;
    ld_pending_d = ld_record;
    ld_rd_d      = ld_record ? id_rd_q : ld_rd_q;

    if (push) begin
      fifo_d[wr_ptr_q] = '{inst: if_inst, pc: if_pc};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      ST_ISSUE:  if (pop && hazard) state_d = ST_BUBBLE;
      ST_BUBBLE: state_d = ST_ISSUE;
      default:   state_d = ST_ISSUE;
    endcase

    if (flush) begin
      count_d      = 2'd0;
      wr_ptr_d     = 1'b0;
      rd_ptr_d     = 1'b0;
      state_d      = ST_ISSUE;
      ld_pending_d = 1'b0;
    end
  end

  always_comb begin
    id_valid_d   = id_valid_q;
    id_inst_d    = id_inst_q;
    id_pc_d      = id_pc_q;
    id_imm_d     = id_imm_q;
    id_rd_d      = id_rd_q;
    id_is_load_d = id_is_load_q;
    id_illegal_d = id_illegal_q;

    if (pop) begin
      id_valid_d   = 1'b1;
      id_inst_d    = head.inst;
      id_pc_d      = head.pc;
      id_imm_d     = head_imm;
      id_rd_d      = head.inst[11:7];
      id_is_load_d = head_is_load;
      id_illegal_d = (head_fmt == FMT_NONE);
    end else if (id_xfer) begin
      id_valid_d = 1'b0;
    end

    if (flush) begin
      id_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      state_q      <= ST_ISSUE;
      ld_pending_q <= 1'b0;
      ld_rd_q      <= 5'd0;
      id_valid_q   <= 1'b0;
      id_inst_q    <= '0;
      id_pc_q      <= '0;
      id_imm_q     <= '0;
      id_rd_q      <= 5'd0;
      id_is_load_q <= 1'b0;
      id_illegal_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      state_q      <= state_d;
      ld_pending_q <= ld_pending_d;
      ld_rd_q      <= ld_rd_d;
      id_valid_q   <= id_valid_d;
      id_inst_q    <= id_inst_d;
      id_pc_q      <= id_pc_d;
      id_imm_q     <= id_imm_d;
      id_rd_q      <= id_rd_d;
      id_is_load_q <= id_is_load_d;
      id_illegal_q <= id_illegal_d;
    end
  end

  // NOTE: buffer storage has no reset; count and pointers decide which entries
  // are meaningful, so the payload flops can stay plain data registers.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign id_inst    = id_inst_q;
  assign id_pc      = id_pc_q;
  assign id_imm     = id_imm_q;
  assign id_rd      = id_rd_q;
  assign id_is_load = id_is_load_q;
  assign id_illegal = id_illegal_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Self-checking bench for decode_issue_ctrl. The driver pushes the expected
// issue record for each accepted instruction into a scoreboard queue; a
// monitor pops and compares on every execute handshake.
module tb_decode_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic [4:0]  id_rd;
  logic        id_is_load;
  logic        id_illegal;

  decode_issue_ctrl #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .flush      (flush),
    .ex_ready   (ex_ready),
    .id_valid   (id_valid),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_imm     (id_imm),
    .id_rd      (id_rd),
    .id_is_load (id_is_load),
    .id_illegal (id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        is_load;
    logic        illegal;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp    = 0;
  int          n_err    = 0;
  int          gap      = 0;
  int          last_gap = -1;
  logic [31:0] next_pc  = 32'h0000_1000;
  logic [31:0] pc_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares on each execute handshake; also tracks the number of
  // id_valid=0 cycles between consecutive handshakes.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && id_valid && ex_ready) begin
      last_gap = gap;
      gap      = 0;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_issue: got inst 0x%08h, expected nothing", id_inst);
      end else begin
        e = sb.pop_front();
        check("sb_inst",    id_inst,           e.inst);
        check("sb_pc",      id_pc,             e.pc);
        check("sb_imm",     id_imm,            e.imm);
        check("sb_rd",      {27'd0, id_rd},    {27'd0, e.rd});
        check("sb_is_load", {31'd0, id_is_load}, {31'd0, e.is_load});
        check("sb_illegal", {31'd0, id_illegal}, {31'd0, e.illegal});
      end
    end else if (rst_n && !id_valid) begin
      gap++;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] word, input logic [31:0] imm,
                      input logic ld, input logic ill);
    int budget;
    budget   = 50;
    if_valid = 1'b1;
    if_inst  = word;
    if_pc    = next_pc;
    @(negedge clk);
    while (!if_ready && budget > 0) begin
      budget--;
      @(negedge clk);
    end
    if (!if_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: if_ready stayed 0, expected 1 for 0x%08h", word);
    end else begin
      sb.push_back('{inst: word, pc: next_pc, imm: imm, rd: word[11:7],
                     is_load: ld, illegal: ill});
      next_pc += 32'd4;
    end
    @(posedge clk);
    #1;
    if_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    if_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    while (sb.size() != 0 && budget > 0) begin
      budget--;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d left in scoreboard, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b1;
    if_valid = 1'b0;
    if_inst  = '0;
    if_pc    = '0;
    flush    = 1'b0;
    ex_ready = 1'b0;
    #1 rst_n = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_if_ready",   {31'd0, if_ready},   32'd0);
    check("rst_id_valid",   {31'd0, id_valid},   32'd0);
    check("rst_id_inst",    id_inst,             32'd0);
    check("rst_id_pc",      id_pc,               32'd0);
    check("rst_id_imm",     id_imm,              32'd0);
    check("rst_id_rd",      {27'd0, id_rd},      32'd0);
    check("rst_id_is_load", {31'd0, id_is_load}, 32'd0);
    check("rst_id_illegal", {31'd0, id_illegal}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("if_ready_after_reset", {31'd0, if_ready}, 32'd1);
    @(posedge clk);
    #1;

    // addi x1,x0,-1: not visible before edge k+1, visible right after it
    ex_ready = 1'b1;
    send(32'hFFF00093, 32'hFFFFFFFF, 1'b0, 1'b0);
    @(negedge clk);
    check("addi_before_k1", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    check("addi_after_k1",  {31'd0, id_valid}, 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Immediate formats, back-to-back at full throughput
    send(32'hFE000EE3, 32'hFFFFFFFC, 1'b0, 1'b0); // beq x0,x0,-4
    send(32'h0000006F, 32'h00000000, 1'b0, 1'b0); // jal x0,0
    send(32'h008000EF, 32'h00000008, 1'b0, 1'b0); // jal x1,8
    send(32'hFE20AC23, 32'hFFFFFFF8, 1'b0, 1'b0); // sw x2,-8(x1)
    send(32'h123451B7, 32'h12345000, 1'b0, 1'b0); // lui x3,0x12345
    send(32'h00000073, 32'h00000000, 1'b0, 1'b0); // ecall
    send(32'h0000007F, 32'h00000000, 1'b0, 1'b1); // unsupported opcode
`ifdef RV_FP_EN
    send(32'h00002007, 32'h00000000, 1'b1, 1'b0); // flw f0,0(x0)
`else
    send(32'h00002007, 32'h00000000, 1'b0, 1'b1); // flw without FP support
`endif
    drain();
    check("throughput_gap", last_gap, 32'd0);

    // Load-use: exactly one bubble
    idle(3);
    send(32'h0000A283, 32'h00000000, 1'b1, 1'b0); // lw x5,0(x1)
    send(32'h00228333, 32'h00000000, 1'b0, 1'b0); // add x6,x5,x2
    drain();
    check("load_use_bubble", last_gap, 32'd1);

    // Independent follower: no bubble
    idle(3);
    send(32'h0000A283, 32'h00000000, 1'b1, 1'b0); // lw x5,0(x1)
    send(32'h00238333, 32'h00000000, 1'b0, 1'b0); // add x6,x7,x2
    drain();
    check("no_dep_no_bubble", last_gap, 32'd0);

    // Back-pressure: 1 held + 2 buffered, outputs stable, order on release
    idle(2);
    ex_ready = 1'b0;
    pc_a     = next_pc;
    send(32'h00100093, 32'h00000001, 1'b0, 1'b0); // addi x1,x0,1
    send(32'h00200113, 32'h00000002, 1'b0, 1'b0); // addi x2,x0,2
    send(32'h00300193, 32'h00000003, 1'b0, 1'b0); // addi x3,x0,3
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_if_ready", {31'd0, if_ready}, 32'd0);
      check("stall_id_valid", {31'd0, id_valid}, 32'd1);
      check("stall_id_inst",  id_inst,           32'h00100093);
      check("stall_id_pc",    id_pc,             pc_a);
      check("stall_id_imm",   id_imm,            32'h00000001);
    end
    @(posedge clk);
    #1 ex_ready = 1'b1;
    drain();

    // Flush with full buffer and a held instruction; same-cycle offer dropped
    ex_ready = 1'b0;
    send(32'h00400213, 32'h00000004, 1'b0, 1'b0); // addi x4,x0,4
    send(32'h00500293, 32'h00000005, 1'b0, 1'b0); // addi x5,x0,5
    send(32'h00600313, 32'h00000006, 1'b0, 1'b0); // addi x6,x0,6
    if_valid = 1'b1;
    if_inst  = 32'h00700393;                      // addi x7,x0,7
    if_pc    = next_pc;
    flush    = 1'b1;
    @(negedge clk);
    check("flush_if_ready",     {31'd0, if_ready}, 32'd0);
    check("flush_pre_id_valid", {31'd0, id_valid}, 32'd1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    if_valid = 1'b0;
    ex_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    check("flush_id_valid",   {31'd0, id_valid}, 32'd0);
    check("flush_if_ready_1", {31'd0, if_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_stays_empty", {31'd0, id_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(32'h00800413, 32'h00000008, 1'b0, 1'b0); // addi x8,x0,8 after flush
    drain();

    // Reset in the middle of traffic
    ex_ready = 1'b0;
    send(32'h00900493, 32'h00000009, 1'b0, 1'b0); // addi x9,x0,9
    send(32'h00A00513, 32'h0000000A, 1'b0, 1'b0); // addi x10,x0,10
    #2 rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst_mid_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_mid_if_ready", {31'd0, if_ready}, 32'd0);
    check("rst_mid_id_inst",  id_inst,           32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    ex_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_empty", {31'd0, id_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
